adc_rx_sample_buf: RTL and testbench

Receive-side counterpart of the TX DAC interface. Takes packed two-antenna ADC samples from the AD9361 ADC path and selects one antenna lane. Optionally decimates, then buffers the IQ words in a synchronous FIFO. Delivers them to the RX accelerator over a valid/ready handshake, with fill-level and overflow reporting. Single clock domain (ADC clock); the controller drives all control inputs in this domain.

---
 rtl/adc_rx_sample_buf.sv | 166 ++++++++++++++++
 tb/tb_adc_rx_sample_buf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rx_sample_buf.sv
// adc_rx_sample_buf
// Receive-side ADC sample buffer. Picks one antenna lane out of the packed
// two-antenna ADC word, optionally decimates by 1/2/4/8, and queues the kept
// IQ words in a first-word-fall-through FIFO. The RX accelerator drains the
// FIFO over a valid/ready handshake. The block reports fill level and a
// sticky overflow flag.
//
// Optional feature macro: RX_DROP_CNT_EN
//   defined   -> drop_count is a 16-bit saturating count of dropped samples
//   undefined -> drop_count is tied to zero and no counter logic is built
module adc_rx_sample_buf #(
  parameter int IQ_DATA_WIDTH       = 16,
  parameter int ADC_PACK_DATA_WIDTH = 64,
  parameter int FIFO_ADDR_WIDTH     = 5
) (
  input  logic                           adc_clk,
  input  logic                           adc_rstn,
  input  logic [ADC_PACK_DATA_WIDTH-1:0] adc_data,
  input  logic                           adc_valid,
  input  logic                           rx_enable,
  input  logic                           ant_flag,
  input  logic [1:0]                     decim_log2,
  input  logic                           ovf_clr,
  output logic [2*IQ_DATA_WIDTH-1:0]     data_to_acc,
  output logic                           data_valid_to_acc,
  input  logic                           acc_ready,
  output logic [FIFO_ADDR_WIDTH:0]       fill_count,
  output logic                           overflow,
  output logic [15:0]                    drop_count
);

  localparam int IQ_W  = 2 * IQ_DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_LEVEL = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  logic [IQ_W-1:0]            lane_sel;
  logic [2:0]                 dcnt;
  logic [2:0]                 dcnt_lim;
  logic [1:0]                 decim_q;
  logic                       keep;
  logic                       full;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   fill_next;
  logic [IQ_W-1:0]            mem [DEPTH];

  // Antenna lane select; ant_flag is in the ADC clock domain so no resync
  always_comb begin
    lane_sel = adc_data[IQ_W-1:0];
    if (ant_flag) begin
      lane_sel = adc_data[2*IQ_W-1:IQ_W];
    end
  end

  // Terminal value of the decimation counter for the selected ratio
  always_comb begin
    dcnt_lim = 3'd0;
    case (decim_log2)
      2'd0:    dcnt_lim = 3'd0;
      2'd1:    dcnt_lim = 3'd1;
      2'd2:    dcnt_lim = 3'd3;
      default: dcnt_lim = 3'd7;
    endcase
  end

  // Decimation counter; restarts when capture is off or the ratio changes
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      dcnt    <= 3'd0;
      decim_q <= 2'd0;
    end else begin
      decim_q <= decim_log2;
      if (!rx_enable || (decim_log2 != decim_q)) begin
        dcnt <= 3'd0;
      end else if (adc_valid) begin
        dcnt <= (dcnt == dcnt_lim) ? 3'd0 : dcnt + 3'd1;
      end
    end
  end

  // Keep/push/pop/drop decisions; a pop frees the slot for a push when full
  always_comb begin
    keep = adc_valid & rx_enable & (dcnt == 3'd0);
    full = (fill_count == FULL_LEVEL);
    pop  = data_valid_to_acc & acc_ready;
    push = keep & (~full | pop);
    drop = keep & full & ~pop;
  end

  // Next fill level from the push/pop pair
  always_comb begin
    fill_next = fill_count;
    case ({push, pop})
      2'b10:   fill_next = fill_count + 1'b1;
      2'b01:   fill_next = fill_count - 1'b1;
      default: fill_next = fill_count;
    endcase
  end

  // Sample storage; contents need no reset because the pointers gate access
  always_ff @(posedge adc_clk) begin
    if (push) begin
      mem[wr_ptr] <= lane_sel;
    end
  end

  // Pointers, fill level and registered head-valid flag
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_count        <= '0;
      data_valid_to_acc <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fill_count        <= fill_next;
      data_valid_to_acc <= (fill_next != '0);
    end
  end

  // Head word falls through; forced to zero while nothing is queued
  always_comb begin
    data_to_acc = '0;
    if (data_valid_to_acc) begin
      data_to_acc = mem[rd_ptr];
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef RX_DROP_CNT_EN
  // Saturating drop counter; a drop coinciding with a clear leaves one
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      drop_count <= 16'd0;
    end else if (ovf_clr) begin
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  // Drop counting not built; the port reads constant zero
  always_comb begin
    drop_count = 16'd0;
  end
`endif

endmodule

// File: tb/tb_adc_rx_sample_buf.sv
// Testbench for adc_rx_sample_buf: directed sequence with a reference queue
// of expected FIFO contents, checked every cycle on the falling clock edge.
module tb_adc_rx_sample_buf;

  logic        adc_clk;
  logic        adc_rstn;
  logic [63:0] adc_data;
  logic        adc_valid;
  logic        rx_enable;
  logic        ant_flag;
  logic [1:0]  decim_log2;
  logic        ovf_clr;
  logic [31:0] data_to_acc;
  logic        data_valid_to_acc;
  logic        acc_ready;
  logic [5:0]  fill_count;
  logic        overflow;
  logic [15:0] drop_count;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] q[$];
  logic [31:0] dq[$];
  logic [2:0]  mdcnt;
  logic [1:0]  mdecim_q;
  logic        exp_ovf;
  logic [15:0] exp_drop;

  adc_rx_sample_buf dut (
    .adc_clk           (adc_clk),
    .adc_rstn          (adc_rstn),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .rx_enable         (rx_enable),
    .ant_flag          (ant_flag),
    .decim_log2        (decim_log2),
    .ovf_clr           (ovf_clr),
    .data_to_acc       (data_to_acc),
    .data_valid_to_acc (data_valid_to_acc),
    .acc_ready         (acc_ready),
    .fill_count        (fill_count),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  // Free-running ADC clock
  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mdcnt    = 3'd0;
    mdecim_q = 2'd0;
    exp_ovf  = 1'b0;
    exp_drop = 16'd0;
  endtask

  // One clock cycle: compare outputs against the queue, then advance the model
  task automatic step();
    bit          m_keep, m_pop, m_push, m_drop;
    int          sz;
    logic [2:0]  lim;
    logic [31:0] lane;
    @(negedge adc_clk);
    sz = q.size();
    checkOutput("valid", 64'(data_valid_to_acc), 64'(sz != 0));
    checkOutput("fill_count", 64'(fill_count), 64'(sz));
    checkOutput("overflow", 64'(overflow), 64'(exp_ovf));
    checkOutput("drop_count", 64'(drop_count), 64'(exp_drop));
    m_pop  = (sz != 0) && acc_ready;
    lane   = ant_flag ? adc_data[63:32] : adc_data[31:0];
    m_keep = adc_valid && rx_enable && (mdcnt == 3'd0);
    m_push = m_keep && ((sz < 32) || m_pop);
    m_drop = m_keep && !m_push;
    if (m_pop) begin
      checkOutput("data", 64'(data_to_acc), 64'(q[0]));
      dq.push_back(data_to_acc);
      void'(q.pop_front());
    end
    if (m_push) q.push_back(lane);
    if (m_drop) exp_ovf = 1'b1;
    else if (ovf_clr) exp_ovf = 1'b0;
`ifdef RX_DROP_CNT_EN
    if (ovf_clr) exp_drop = m_drop ? 16'd1 : 16'd0;
    else if (m_drop && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
    lim = 3'((4'd1 << decim_log2) - 4'd1);
    if (!rx_enable || (decim_log2 != mdecim_q)) mdcnt = 3'd0;
    else if (adc_valid) mdcnt = (mdcnt == lim) ? 3'd0 : mdcnt + 3'd1;
    mdecim_q = decim_log2;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d);
    adc_valid = v;
    adc_data  = d;
    step();
  endtask

  initial begin
    adc_rstn   = 1'b0;
    adc_data   = 64'd0;
    adc_valid  = 1'b0;
    rx_enable  = 1'b0;
    ant_flag   = 1'b0;
    decim_log2 = 2'd0;
    ovf_clr    = 1'b0;
    acc_ready  = 1'b0;
    modelReset();
    repeat (2) @(posedge adc_clk);
    #1;
    checkOutput("rst_valid", 64'(data_valid_to_acc), 64'd0);
    checkOutput("rst_fill", 64'(fill_count), 64'd0);
    checkOutput("rst_data", 64'(data_to_acc), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    adc_rstn = 1'b1;

    $display("[TB] test 1: single sample, latency 1");
    rx_enable = 1'b1;
    acc_ready = 1'b1;
    dq.delete();
    applyStimulus(1'b1, 64'hAAAA_BBBB_1111_2222);
    applyStimulus(1'b0, 64'd0);
    applyStimulus(1'b0, 64'd0);
    checkOutput("t1_count", 64'(dq.size()), 64'd1);
    checkOutput("t1_word", 64'((dq.size() > 0) ? dq[0] : 32'hx), 64'h1111_2222);
    checkOutput("t1_fill", 64'(fill_count), 64'd0);

    $display("[TB] test 2: lane 1, decimate by 4");
    ant_flag   = 1'b1;
    decim_log2 = 2'd2;
    applyStimulus(1'b0, 64'd0);
    applyStimulus(1'b0, 64'd0);
    dq.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, {32'(i), 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'd0);
    checkOutput("t2_count", 64'(dq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("t2_word", 64'((i < dq.size()) ? dq[i] : 32'hx), 64'(4 * i));

    $display("[TB] test 3: overflow and clear");
    ant_flag   = 1'b0;
    decim_log2 = 2'd0;
    acc_ready  = 1'b0;
    applyStimulus(1'b0, 64'd0);
    applyStimulus(1'b0, 64'd0);
    dq.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, {32'hFFFF_0000, 32'(100 + i)});
    applyStimulus(1'b0, 64'd0);
    checkOutput("t3_fill", 64'(fill_count), 64'd32);
    checkOutput("t3_ovf", 64'(overflow), 64'd1);
`ifdef RX_DROP_CNT_EN
    checkOutput("t3_drop", 64'(drop_count), 64'd8);
`else
    checkOutput("t3_drop", 64'(drop_count), 64'd0);
`endif
    ovf_clr = 1'b1;
    applyStimulus(1'b0, 64'd0);
    ovf_clr = 1'b0;
    applyStimulus(1'b0, 64'd0);
    checkOutput("t3_ovf_clr", 64'(overflow), 64'd0);
    checkOutput("t3_drop_clr", 64'(drop_count), 64'd0);
    acc_ready = 1'b1;
    for (int i = 0; i < 34; i++) applyStimulus(1'b0, 64'd0);
    checkOutput("t3_count", 64'(dq.size()), 64'd32);
    for (int i = 0; i < 32; i++)
      checkOutput("t3_order", 64'((i < dq.size()) ? dq[i] : 32'hx), 64'(100 + i));

    $display("[TB] test 4: full FIFO with simultaneous push and pop");
    acc_ready = 1'b0;
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, {32'd0, 32'(500 + i)});
    acc_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, {32'd0, 32'(600 + i)});
    acc_ready = 1'b0;
    applyStimulus(1'b0, 64'd0);
    checkOutput("t4_fill", 64'(fill_count), 64'd32);
    checkOutput("t4_ovf", 64'(overflow), 64'd0);
    acc_ready = 1'b1;
    for (int i = 0; i < 34; i++) applyStimulus(1'b0, 64'd0);
    checkOutput("t4_empty", 64'(fill_count), 64'd0);

    $display("[TB] test 5: rx_enable falls mid-stream");
    acc_ready = 1'b0;
    dq.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, {32'd0, 32'(700 + i)});
    rx_enable = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, {32'd0, 32'(800 + i)});
    acc_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, {32'd0, 32'(900 + i)});
    checkOutput("t5_count", 64'(dq.size()), 64'd5);
    checkOutput("t5_valid", 64'(data_valid_to_acc), 64'd0);

    $display("[TB] test 6: reset mid-transfer");
    rx_enable = 1'b1;
    acc_ready = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, {32'd0, 32'(1000 + i)});
    adc_valid = 1'b0;
    checkOutput("t6_fill_pre", 64'(fill_count), 64'd12);
    #1;
    adc_rstn = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(data_valid_to_acc), 64'd0);
    checkOutput("t6_rst_fill", 64'(fill_count), 64'd0);
    checkOutput("t6_rst_data", 64'(data_to_acc), 64'd0);
    modelReset();
    @(posedge adc_clk);
    #1;
    adc_rstn  = 1'b1;
    acc_ready = 1'b1;
    dq.delete();
    applyStimulus(1'b1, 64'h0000_0000_5555_6666);
    applyStimulus(1'b0, 64'd0);
    applyStimulus(1'b0, 64'd0);
    checkOutput("t6_count", 64'(dq.size()), 64'd1);
    checkOutput("t6_word", 64'((dq.size() > 0) ? dq[0] : 32'hx), 64'h5555_6666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
